// File: rtl/regbus_arb_pkg.sv
// regbus_arb_pkg: shared encodings for the register-bus round-robin arbiter
package regbus_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/rr_grant_select.sv
// rr_grant_select: combinational round-robin winner search starting at ptr
module rr_grant_select #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_valid,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] g
);
  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;
  logic [W:0]   w_sum;
  // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner offset
  assign w_rot = N'({req_valid, req_valid} >> ptr);
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_off = W'(k);
  end
  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign g     = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
  assign any   = |req_valid;
endmodule

// File: rtl/regbus_rr_arbiter.sv
// regbus_rr_arbiter: shares the register-file bus between NUM_REQ requesters,
// one transaction in flight, round-robin order, all outputs registered.
module regbus_rr_arbiter
  import regbus_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]     req_wstrb,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic [ADDR_WIDTH-1:0]         user_wr_addr,
  output logic [DATA_WIDTH-1:0]         user_wr_data,
  output logic [STRB_W-1:0]             user_wr_strb,
  output logic                          user_wr_en,
  input  logic [1:0]                    user_wr_resp,
  output logic [ADDR_WIDTH-1:0]         user_rd_addr,
  output logic                          user_rd_en,
  input  logic [DATA_WIDTH-1:0]         user_rd_data,
  input  logic [1:0]                    user_rd_resp
);
  arb_state_t      r_state;
  logic [ID_W-1:0] r_ptr;
  logic            w_any;
  logic [ID_W-1:0] w_g;
  logic            w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  rr_grant_select #(.N(NUM_REQ)) u_sel (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .any       (w_any),
    .g         (w_g)
  );
  assign w_we    = req_we[w_g];
  assign w_addr  = req_addr[w_g*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata = req_wdata[w_g*DATA_WIDTH +: DATA_WIDTH];
  assign w_wstrb = req_wstrb[w_g*STRB_W +: STRB_W];
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      req_ack      <= '0;
      rsp_rdata    <= '0;
      rsp_resp     <= RESP_OKAY;
      busy         <= 1'b0;
      grant_id     <= '0;
      user_wr_addr <= '0;
      user_wr_data <= '0;
      user_wr_strb <= '0;
      user_wr_en   <= 1'b0;
      user_rd_addr <= '0;
      user_rd_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          grant_id   <= w_g;
          busy       <= 1'b1;
          user_wr_en <= w_we;
          user_rd_en <= !w_we;
          r_state    <= ST_ISSUE;
          if (w_we) begin
            user_wr_addr <= w_addr;
            user_wr_data <= w_wdata;
            user_wr_strb <= w_wstrb;
          end else begin
            user_rd_addr <= w_addr;
          end
        end
        // The write enable still marks the transaction type during ISSUE
        ST_ISSUE: begin
          rsp_resp   <= user_wr_en ? user_wr_resp : user_rd_resp;
          rsp_rdata  <= user_wr_en ? '0 : user_rd_data;
          req_ack    <= NUM_REQ'(1) << grant_id;
          user_wr_en <= 1'b0;
          user_rd_en <= 1'b0;
          r_state    <= ST_ACK;
        end
        ST_ACK: begin
          req_ack <= '0;
          busy    <= 1'b0;
          r_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// tb_regbus_rr_arbiter: directed vectors for the register-bus round-robin arbiter
module tb_regbus_rr_arbiter;
  import regbus_arb_pkg::*;
  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   req_valid, req_we, req_ack;
  logic [127:0] req_addr, req_wdata;
  logic [15:0]  req_wstrb;
  logic [31:0]  rsp_rdata, user_wr_addr, user_wr_data, user_rd_addr, user_rd_data;
  logic [1:0]   rsp_resp, grant_id, user_wr_resp, user_rd_resp;
  logic [3:0]   user_wr_strb;
  logic         busy, user_wr_en, user_rd_en;
  int n_vec = 0;
  int n_bad = 0;
  int exp_g [4] = '{0, 2, 0, 2};
  regbus_rr_arbiter dut (
    .aclk         (aclk),
    .areset       (areset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_ack      (req_ack),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .busy         (busy),
    .grant_id     (grant_id),
    .user_wr_addr (user_wr_addr),
    .user_wr_data (user_wr_data),
    .user_wr_strb (user_wr_strb),
    .user_wr_en   (user_wr_en),
    .user_wr_resp (user_wr_resp),
    .user_rd_addr (user_rd_addr),
    .user_rd_en   (user_rd_en),
    .user_rd_data (user_rd_data),
    .user_rd_resp (user_rd_resp)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask
  task automatic chk_zero(input string t);
    chk({t, "_ack"}, 64'(req_ack), 0);
    chk({t, "_rdata"}, 64'(rsp_rdata), 0);
    chk({t, "_resp"}, 64'(rsp_resp), 0);
    chk({t, "_busy"}, 64'(busy), 0);
    chk({t, "_gid"}, 64'(grant_id), 0);
    chk({t, "_wr_addr"}, 64'(user_wr_addr), 0);
    chk({t, "_wr_data"}, 64'(user_wr_data), 0);
    chk({t, "_wr_strb"}, 64'(user_wr_strb), 0);
    chk({t, "_wr_en"}, 64'(user_wr_en), 0);
    chk({t, "_rd_addr"}, 64'(user_rd_addr), 0);
    chk({t, "_rd_en"}, 64'(user_rd_en), 0);
  endtask
  initial begin
    areset = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    user_wr_resp = RESP_OKAY; user_rd_resp = RESP_OKAY; user_rd_data = '0;
    repeat (2) tick;
    chk_zero("rst");
    areset = 1'b0;
    // single write from req0; valid dropped during ISSUE must still ack
    req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hDEADBEEF; req_wstrb[3:0] = 4'hF;
    req_we = 4'b0001; req_valid = 4'b0001;
    tick;
    chk("w0_wr_en", 64'(user_wr_en), 1);
    chk("w0_rd_en", 64'(user_rd_en), 0);
    chk("w0_addr", 64'(user_wr_addr), 64'h10);
    chk("w0_data", 64'(user_wr_data), 64'hDEADBEEF);
    chk("w0_strb", 64'(user_wr_strb), 64'hF);
    chk("w0_busy", 64'(busy), 1);
    chk("w0_ack_early", 64'(req_ack), 0);
    req_valid = '0;
    tick;
    chk("w0_ack", 64'(req_ack), 64'b0001);
    chk("w0_resp", 64'(rsp_resp), 0);
    chk("w0_en_off", 64'(user_wr_en), 0);
    tick;
    chk("w0_ack_off", 64'(req_ack), 0);
    chk("w0_idle", 64'(busy), 0);
    // read from req1 with SLVERR
    req_addr[63:32] = 32'h20; req_we = 4'b0000; req_valid = 4'b0010;
    user_rd_data = 32'h12345678; user_rd_resp = RESP_SLVERR;
    tick;
    chk("r1_rd_en", 64'(user_rd_en), 1);
    chk("r1_wr_en", 64'(user_wr_en), 0);
    chk("r1_rd_addr", 64'(user_rd_addr), 64'h20);
    chk("r1_wr_hold", 64'(user_wr_addr), 64'h10);
    chk("r1_gid", 64'(grant_id), 1);
    tick;
    chk("r1_ack", 64'(req_ack), 64'b0010);
    chk("r1_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("r1_resp", 64'(rsp_resp), 64'(RESP_SLVERR));
    req_valid = '0;
    tick;
    // zero-strobe write from req2: still issued, rdata cleared, wr_resp used
    req_addr[95:64] = 32'h30; req_wdata[95:64] = 32'hA5A5; req_wstrb[11:8] = 4'h0;
    req_we = 4'b0100; req_valid = 4'b0100;
    tick;
    chk("w2_wr_en", 64'(user_wr_en), 1);
    chk("w2_strb", 64'(user_wr_strb), 0);
    chk("w2_gid", 64'(grant_id), 2);
    chk("w2_rd_hold", 64'(user_rd_addr), 64'h20);
    tick;
    chk("w2_ack", 64'(req_ack), 64'b0100);
    chk("w2_rdata", 64'(rsp_rdata), 0);
    chk("w2_resp", 64'(rsp_resp), 0);
    req_valid = '0;
    tick;
    areset = 1'b1;
    tick;
    areset = 1'b0;
    // all four requesting from ptr=0
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = 32'(32'h100 + 4 * i);
      req_wdata[i*32 +: 32] = 32'(32'h1000 + i);
      req_wstrb[i*4 +: 4]   = (i == 2) ? 4'h0 : 4'hF;
    end
    req_we = 4'b1111; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      user_wr_resp = (i == 3) ? RESP_SLVERR : RESP_OKAY;
      tick;
      chk("all_gid", 64'(grant_id), 64'(i));
      chk("all_wr_en", 64'(user_wr_en), 1);
      chk("all_addr", 64'(user_wr_addr), 64'(32'h100 + 4 * i));
      chk("all_data", 64'(user_wr_data), 64'(32'h1000 + i));
      chk("all_no_ack", 64'(req_ack), 0);
      tick;
      chk("all_ack", 64'(req_ack), 64'(4'b0001 << i));
      chk("all_en_off", 64'(user_wr_en), 0);
      chk("all_resp", 64'(rsp_resp), (i == 3) ? 64'(RESP_SLVERR) : 64'(RESP_OKAY));
      tick;
      chk("all_gap_ack", 64'(req_ack), 0);
      chk("all_gap_busy", 64'(busy), 0);
    end
    user_wr_resp = RESP_OKAY;
    // wrap after grant 3, then ptr=1 makes req3 next
    req_valid = 4'b1001;
    tick;
    chk("wrap_gid0", 64'(grant_id), 0);
    tick;
    chk("wrap_ack0", 64'(req_ack), 64'b0001);
    tick;
    tick;
    chk("wrap_gid3", 64'(grant_id), 3);
    tick;
    chk("wrap_ack3", 64'(req_ack), 64'b1000);
    req_valid = '0;
    tick;
    // req0 continuous with req2 waiting
    req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("alt_gid", 64'(grant_id), 64'(exp_g[i]));
      tick;
      chk("alt_ack", 64'(req_ack), 64'(4'b0001 << exp_g[i]));
      tick;
    end
    req_valid = '0;
    tick;
    // async reset during ISSUE, ptr was 3
    req_valid = 4'b0001;
    tick;
    chk("ar_gid", 64'(grant_id), 0);
    chk("ar_wr_en", 64'(user_wr_en), 1);
    #2;
    areset = 1'b1;
    req_valid = 4'b1010;
    #1;
    chk_zero("arst");
    tick;
    chk("arst_hold_ack", 64'(req_ack), 0);
    areset = 1'b0;
    tick;
    chk("post_gid1", 64'(grant_id), 1);
    chk("post_addr1", 64'(user_wr_addr), 64'h104);
    tick;
    chk("post_ack1", 64'(req_ack), 64'b0010);
    tick;
    tick;
    chk("post_gid3", 64'(grant_id), 3);
    tick;
    chk("post_ack3", 64'(req_ack), 64'b1000);
    req_valid = '0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
